// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. It issues one program memory read per cycle (when
// buffer space allows) and captures each returned word together with its
// address into a 2-entry buffer. The buffer head is presented to decode with a
// valid/ready handshake. A branch/jump redirect flushes the buffer, discards
// the read still in flight and restarts fetching at the redirect target.
//
// Ports
//   clk            : single clock, all state changes on its rising edge
//   rst            : asynchronous, active-high reset
//   mem_addr       : program memory byte address (the fetch pc)
//   mem_rd_strobe  : program memory read request
//   mem_wr_strobe  : program memory byte write enables, always 4'b0000
//   mem_data       : read data, valid the cycle after mem_rd_strobe
//   redirect_valid : branch/jump redirect request
//   redirect_pc    : redirect target byte address
//   if_valid       : instruction available to decode
//   if_ready       : decode accepts the instruction
//   if_instr       : instruction word at the buffer head
//   if_pc          : byte address of if_instr
//   fault          : misaligned-redirect fault
//
// Configuration macro
//   IFETCH_ALIGN_CHECK_EN : when defined, a redirect whose target has
//   redirect_pc[1:0] != 0 parks the stage in a FAULT state (fault = 1, no
//   fetching) until an aligned redirect arrives. When undefined, the low two
//   target bits are dropped and fault is tied low.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_strobe,
  output logic [3:0]  mem_wr_strobe,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault
);

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;
  // State entered on a redirect whose target cannot be fetched
  localparam state_t ST_BAD = ST_FAULT;
`else
  typedef enum logic [0:0] {ST_RUN = 1'b0} state_t;
  localparam state_t ST_BAD = ST_RUN;
`endif

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] tag_r;
  logic        in_flight_r;
  logic        issue_s;

  // Two-entry buffer kept as a shift structure: head is always entry 0
  logic [1:0]  count_r, count_next_s;
  logic [31:0] head_pc_r, head_instr_r, tail_pc_r, tail_instr_r;
  logic [31:0] head_pc_next_s, head_instr_next_s, tail_pc_next_s, tail_instr_next_s;

  logic        pop_s, push_s;
  logic [2:0]  occ_s;
  logic [31:0] target_s;
  logic        target_ok_s;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_s    = redirect_pc;
  assign target_ok_s = (redirect_pc[1:0] == 2'b00);
  assign fault       = (state_r == ST_FAULT);
`else
  assign target_s    = redirect_pc & 32'hFFFF_FFFC;
  assign target_ok_s = 1'b1;
  assign fault       = 1'b0;
`endif

  assign if_valid      = (count_r != 2'd0);
  assign if_pc         = head_pc_r;
  assign if_instr      = head_instr_r;
  assign pop_s         = if_valid && if_ready;
  // A response arriving in a redirect cycle belongs to the abandoned stream
  assign push_s        = in_flight_r && !redirect_valid;
  // Slots committed after this cycle if nothing new were issued
  assign occ_s         = {1'b0, count_r} + {2'b00, in_flight_r} - {2'b00, pop_s};
  assign mem_addr      = pc_r;
  assign mem_rd_strobe = issue_s;
  assign mem_wr_strobe = 4'b0000;

  // Next-state, next-pc and issue decision
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    issue_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (redirect_valid) begin
          if (target_ok_s) begin
            pc_next_s = target_s;
          end else begin
            state_next_s = ST_BAD;
          end
        end else if (!rst && (occ_s < 3'd2)) begin
          issue_s   = 1'b1;
          pc_next_s = pc_r + 32'd4;
        end else begin
          pc_next_s = pc_r;
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        if (redirect_valid && target_ok_s) begin
          state_next_s = ST_RUN;
          pc_next_s    = target_s;
        end else begin
          state_next_s = ST_FAULT;
        end
      end
`endif
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // Buffer update: flush wins, otherwise push/pop with order preserved
  always_comb begin
    count_next_s      = count_r;
    head_pc_next_s    = head_pc_r;
    head_instr_next_s = head_instr_r;
    tail_pc_next_s    = tail_pc_r;
    tail_instr_next_s = tail_instr_r;
    if (redirect_valid) begin
      count_next_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_pc_next_s    = tag_r;
            head_instr_next_s = mem_data;
            count_next_s      = 2'd1;
          end else if (count_r == 2'd1) begin
            tail_pc_next_s    = tag_r;
            tail_instr_next_s = mem_data;
            count_next_s      = 2'd2;
          end else begin
            count_next_s = count_r;
          end
        end
        2'b01: begin
          head_pc_next_s    = tail_pc_r;
          head_instr_next_s = tail_instr_r;
          count_next_s      = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_pc_next_s    = tail_pc_r;
            head_instr_next_s = tail_instr_r;
            tail_pc_next_s    = tag_r;
            tail_instr_next_s = mem_data;
          end else begin
            head_pc_next_s    = tag_r;
            head_instr_next_s = mem_data;
          end
        end
        default: begin
          count_next_s = count_r;
        end
      endcase
    end
  end

  // State, pc and in-flight tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      in_flight_r <= 1'b0;
      tag_r       <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      in_flight_r <= issue_s;
      tag_r       <= issue_s ? pc_r : tag_r;
    end
  end

  // Instruction buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= 2'd0;
      head_pc_r    <= 32'h0000_0000;
      head_instr_r <= 32'h0000_0000;
      tail_pc_r    <= 32'h0000_0000;
      tail_instr_r <= 32'h0000_0000;
    end else begin
      count_r      <= count_next_s;
      head_pc_r    <= head_pc_next_s;
      head_instr_r <= head_instr_next_s;
      tail_pc_r    <= tail_pc_next_s;
      tail_instr_r <= tail_instr_next_s;
    end
  end

endmodule
